gpr_wb_arbiter: RTL and testbench

- Sequences the single write port of the 8-entry general-purpose register file.
- After reset, it first clears all eight registers to zero, one per cycle.
- It then shares the write port between two writeback requesters, A (ALU) and B (load unit), using a valid/ready handshake and round-robin arbitration.
- It sits between the execute/memory writeback stages and the register-file write inputs.

---
 rtl/gpr_wb_arbiter.sv | 95 +++++++++
 tb/tb_gpr_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// Write-port sequencer for the 8-entry GPR file: clears every register after
// reset, then round-robins the port between writeback requesters A and B.
module gpr_wb_arbiter #(
  parameter int DATA_WIDTH = 31,
  parameter bit ZERO_LOCK  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [2:0]            a_dest,
  input  logic [DATA_WIDTH:0]   a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [2:0]            b_dest,
  input  logic [DATA_WIDTH:0]   b_data,
  output logic                  init_busy,
  output logic                  reg_write_en,
  output logic [2:0]            reg_write_dest,
  output logic [DATA_WIDTH:0]   reg_write_data,
  output logic [7:0]            conflict_cnt
);

  typedef enum logic {INIT, RUN} state_t;

  state_t     state;
  logic [2:0] clr_ptr;
  logic       rr_last;  // 0: A won the last transfer, 1: B did
  logic       a_fire;
  logic       b_fire;

  assign init_busy = (state == INIT);

  // Handshake: a write transfers on the edge where valid && ready are both
  // high. Requesters hold valid/dest/data until ready; ready is derived from
  // the valids and rr_last only, never from the other ready.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state == RUN) begin
      if (a_valid && b_valid) begin
        a_ready = rr_last;
        b_ready = !rr_last;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= INIT;
      clr_ptr        <= 3'd0;
      rr_last        <= 1'b1;
      reg_write_en   <= 1'b0;
      reg_write_dest <= 3'd0;
      reg_write_data <= '0;
      conflict_cnt   <= 8'd0;
    end else begin
      case (state)
        INIT: begin
          // Register 0 is cleared here even when ZERO_LOCK is set.
          reg_write_en   <= 1'b1;
          reg_write_dest <= clr_ptr;
          reg_write_data <= '0;
          clr_ptr        <= clr_ptr + 3'd1;
          if (clr_ptr == 3'd7) state <= RUN;
        end
        RUN: begin
          if (a_valid && b_valid && conflict_cnt != 8'hFF)
            conflict_cnt <= conflict_cnt + 8'd1;
          if (a_fire) begin
            reg_write_en   <= !(ZERO_LOCK && a_dest == 3'd0);
            reg_write_dest <= a_dest;
            reg_write_data <= a_data;
            rr_last        <= 1'b0;
          end else if (b_fire) begin
            reg_write_en   <= !(ZERO_LOCK && b_dest == 3'd0);
            reg_write_dest <= b_dest;
            reg_write_data <= b_data;
            rr_last        <= 1'b1;
          end else begin
            reg_write_en <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: expected register-file writes are queued
// when grants are issued and a negedge monitor matches them against the DUT.
module tb_gpr_wb_arbiter;

  localparam int DW = 31;
  localparam bit ZL = 1'b1;

  logic          clk;
  logic          rst;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [2:0]    a_dest, b_dest;
  logic [DW:0]   a_data, b_data;
  logic          init_busy;
  logic          reg_write_en;
  logic [2:0]    reg_write_dest;
  logic [DW:0]   reg_write_data;
  logic [7:0]    conflict_cnt;

  int errors = 0;
  int checks = 0;
  logic [DW+3:0] exp_q[$];

  gpr_wb_arbiter #(.DATA_WIDTH(DW), .ZERO_LOCK(ZL)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .init_busy(init_busy), .reg_write_en(reg_write_en),
    .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .conflict_cnt(conflict_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every issued write must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && reg_write_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got dest %0d data 0x%0h expected none",
                 reg_write_dest, reg_write_data);
      end else begin
        check("write", {reg_write_dest, reg_write_data}, exp_q.pop_front());
      end
    end
  end

  // driver: one clock cycle of stimulus with hand-derived ready/busy values
  task automatic cycle(input string tag,
                       input logic av, input logic [2:0] ad, input logic [DW:0] adv,
                       input logic bv, input logic [2:0] bd, input logic [DW:0] bdv,
                       input logic ea, input logic eb, input logic ebusy);
    a_valid = av; a_dest = ad; a_data = adv;
    b_valid = bv; b_dest = bd; b_data = bdv;
    @(negedge clk);
    check({tag, "_a_ready"}, a_ready, ea);
    check({tag, "_b_ready"}, b_ready, eb);
    check({tag, "_init_busy"}, init_busy, ebusy);
    @(posedge clk);
    if (ea && !(ZL && ad == 3'd0)) exp_q.push_back({ad, adv});
    if (eb && !(ZL && bd == 3'd0)) exp_q.push_back({bd, bdv});
    #1;
  endtask

  task automatic idle(input string tag, input logic ebusy);
    cycle(tag, 1'b0, 3'd0, '0, 1'b0, 3'd0, '0, 1'b0, 1'b0, ebusy);
  endtask

  task automatic push_clears(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({i[2:0], {(DW+1){1'b0}}});
  endtask

  task automatic reset_and_clear(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_write_en"}, reg_write_en, 1'b0);
    check({tag, "_rst_busy"}, init_busy, 1'b1);
    check({tag, "_rst_conflict"}, conflict_cnt, 8'd0);
    @(posedge clk); #1;
    push_clears(8);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) idle({tag, "_clear"}, 1'b1);
  endtask

  initial begin
    logic [DW:0] ad, bd;
    rst = 1'b0;
    a_valid = 1'b0; a_dest = '0; a_data = '0;
    b_valid = 1'b0; b_dest = '0; b_data = '0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("reset_write_en", reg_write_en, 1'b0);
    check("reset_dest", reg_write_dest, 3'd0);
    check("reset_data", reg_write_data, '0);
    check("reset_conflict", conflict_cnt, 8'd0);
    check("reset_busy", init_busy, 1'b1);
    check("reset_ready", {a_ready, b_ready}, 2'b00);

    // 1: clear sequence, then first RUN cycle shows dest 7 and busy drops
    reset_and_clear("t1");
    idle("t1_run", 1'b0);

    // 2: single A write
    cycle("t2", 1'b1, 3'd3, 32'h1234, 1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b0);
    idle("t2_after", 1'b0);
    @(negedge clk);
    check("t2_en_drops", reg_write_en, 1'b0);
    @(posedge clk); #1;

    // lone B write leaves rr_last=B so the next tie starts with A
    cycle("t3_pre", 1'b0, 3'd0, '0, 1'b1, 3'd4, 32'h55, 1'b0, 1'b1, 1'b0);
    // 3: four tie cycles alternate A,B,A,B; losers hold their request
    cycle("t3_c1", 1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22, 1'b1, 1'b0, 1'b0);
    cycle("t3_c2", 1'b1, 3'd1, 32'h33, 1'b1, 3'd2, 32'h22, 1'b0, 1'b1, 1'b0);
    cycle("t3_c3", 1'b1, 3'd1, 32'h33, 1'b1, 3'd2, 32'h44, 1'b1, 1'b0, 1'b0);
    cycle("t3_c4", 1'b1, 3'd1, 32'h55, 1'b1, 3'd2, 32'h44, 1'b0, 1'b1, 1'b0);
    check("t3_conflict", conflict_cnt, 8'd4);
    cycle("t3_c5", 1'b1, 3'd1, 32'h55, 1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b0);
    check("t3_conflict_hold", conflict_cnt, 8'd4);
    idle("t3_idle", 1'b0);

    // 4: same destination after reset: A then B, final value 0xBBBB
    reset_and_clear("t4");
    cycle("t4_c1", 1'b1, 3'd5, 32'hAAAA, 1'b1, 3'd5, 32'hBBBB, 1'b1, 1'b0, 1'b0);
    cycle("t4_c2", 1'b0, 3'd0, '0, 1'b1, 3'd5, 32'hBBBB, 1'b0, 1'b1, 1'b0);
    idle("t4_idle", 1'b0);
    check("t4_last_dest", reg_write_dest, 3'd5);
    check("t4_last_data", reg_write_data, 32'hBBBB);
    check("t4_conflict", conflict_cnt, 8'd1);

    // 5: register 0 write accepted but not issued
    cycle("t5", 1'b1, 3'd0, 32'h77, 1'b0, 3'd0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_zero_lock_en", reg_write_en, 1'b0);
    @(posedge clk); #1;

    // 6: reset during clear edge 4 drops that write and restarts from 0
    rst = 1'b1;
    @(posedge clk); #1;
    push_clears(3);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) idle("t6_part", 1'b1);
    rst = 1'b1;
    #1;
    check("t6_midclear_en", reg_write_en, 1'b0);
    check("t6_midclear_busy", init_busy, 1'b1);
    @(posedge clk); #1;
    push_clears(8);
    rst = 1'b0;
    ad = 32'hA000_0000;
    bd = 32'hB000_0000;
    // both requesters valid during the clear: no readies, no counting
    for (int k = 0; k < 8; k++)
      cycle("t6_clear", 1'b1, 3'd1, ad, 1'b1, 3'd2, bd, 1'b0, 1'b0, 1'b1);
    check("t6_conflict_init", conflict_cnt, 8'd0);
    for (int i = 0; i < 300; i++) begin
      cycle("t6_tie", 1'b1, 3'd1, ad, 1'b1, 3'd2, bd, (i % 2) == 0, (i % 2) == 1, 1'b0);
      if ((i % 2) == 0) ad = ad + 1; else bd = bd + 1;
      if (i == 254) check("t6_conflict_255", conflict_cnt, 8'd255);
    end
    check("t6_conflict_sat", conflict_cnt, 8'd255);
    idle("t6_idle", 1'b0);
    idle("t6_idle2", 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
